// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI bus arbiter
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, CMPLT} arb_state_t;
    localparam logic [15:0] TMO_RESP = 16'hFFFF;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last owner
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);
    logic [IW-1:0] cand;
    always_comb begin
        idx = '0;
        cand = '0;
        // descending scan so the candidate nearest to last+1 is written last and wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NUM_REQ);
            if (req[cand]) idx = cand;
        end
        gnt = (|req) ? (NUM_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/spi_bus_arb.sv
// spi_bus_arb: shares one SPI_mnrch engine among NUM_REQ requesters with round-robin and watchdog
module spi_bus_arb
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TMO_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*16-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      err,
    output logic [15:0]             resp,
    output logic                    snd,
    output logic [15:0]             cmd,
    input  logic                    spi_done,
    input  logic [15:0]             spi_resp,
    input  logic                    mnrch_SS_n,
    output logic [NUM_REQ-1:0]      SS_n
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TMO_CYC);
    localparam logic [WW-1:0] WD_MAX = WW'(TMO_CYC - 1);

    arb_state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, last_q, last_d, gnt_idx;
    logic [NUM_REQ-1:0] gnt, own_oh;
    logic [15:0] cmd_q, cmd_d, resp_q, resp_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic abort_q, abort_d, snd_q, snd_d, spi_done_q, spi_rise;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    // only a fresh rising edge completes; a level left high from a previous transfer is ignored
    assign spi_rise = spi_done & ~spi_done_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        resp_d  = resp_q;
        abort_d = abort_q;
        snd_d   = state_q == LAUNCH;
        wdog_d  = (state_q == BUSY && wdog_q != WD_MAX) ? wdog_q + 1'b1 : wdog_q;
        case (state_q)
            IDLE: if (|gnt) begin
                owner_d = gnt_idx;
                cmd_d   = req_cmd[16*gnt_idx +: 16];
                state_d = LAUNCH;
            end
            LAUNCH: begin
                wdog_d  = '0;
                state_d = BUSY;
            end
            BUSY: if (spi_rise) begin
                resp_d  = spi_resp;
                state_d = CMPLT;
            end else if (wdog_q == WD_MAX) begin
                resp_d  = TMO_RESP;
                abort_d = 1'b1;
                state_d = CMPLT;
            end
            default: begin
                last_d  = owner_q;
                abort_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            cmd_q      <= '0;
            resp_q     <= '0;
            wdog_q     <= '0;
            abort_q    <= 1'b0;
            snd_q      <= 1'b0;
            spi_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            resp_q     <= resp_d;
            wdog_q     <= wdog_d;
            abort_q    <= abort_d;
            snd_q      <= snd_d;
            spi_done_q <= spi_done;
        end
    end

    assign own_oh = NUM_REQ'(1) << owner_q;
    assign snd    = snd_q;
    assign cmd    = cmd_q;
    assign resp   = resp_q;
    assign done   = (state_q == CMPLT) ? own_oh : '0;
    assign err    = (state_q == CMPLT && abort_q) ? own_oh : '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ss
        assign SS_n[g] = (state_q != IDLE && owner_q == IW'(g)) ? mnrch_SS_n : 1'b1;
    end
endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: directed tests with a transaction-level reference model checked every cycle
module tb_spi_bus_arb;
    localparam int N = 2;
    localparam int TMO = 64;

    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [16*N-1:0] req_cmd = '0;
    logic [N-1:0] done, err, SS_n;
    logic [15:0] resp, cmd, spi_resp;
    logic snd, spi_done, mnrch_SS_n;

    int checks = 0, passed = 0, cyc = 0;
    int hold_hi = 0, delay = 6, rise_cyc = 0;
    logic hang = 1'b0;
    logic [15:0] slv_resp = '0;

    spi_bus_arb #(.NUM_REQ(N), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .done(done), .err(err),
        .resp(resp), .snd(snd), .cmd(cmd), .spi_done(spi_done), .spi_resp(spi_resp),
        .mnrch_SS_n(mnrch_SS_n), .SS_n(SS_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        checks++;
        $display("FAIL %s: event did not occur within cycle budget", nm);
    endtask

    // reference model: one transaction record, timed from the grant
    logic m_act = 0, m_fin = 0, m_err = 0, m_prev = 0;
    int m_age = 0, m_own = 0, m_last = N - 1;
    logic [15:0] m_cmd = '0, m_resp = '0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 0; m_fin <= 0; m_err <= 0; m_prev <= 0;
            m_age <= 0; m_own <= 0; m_last <= N - 1; m_cmd <= '0; m_resp <= '0;
        end else begin
            m_prev <= spi_done;
            if (m_fin) begin
                m_fin <= 0; m_act <= 0; m_err <= 0; m_last <= m_own;
            end else if (!m_act) begin
                if (|req) begin
                    m_act <= 1; m_age <= 0; m_own <= pick(req, m_last);
                    m_cmd <= req_cmd[16*pick(req, m_last) +: 16];
                end
            end else begin
                m_age <= m_age + 1;
                if (m_age >= 1 && spi_done && !m_prev) begin
                    m_resp <= spi_resp; m_fin <= 1;
                end else if (m_age == TMO) begin
                    m_resp <= 16'hFFFF; m_fin <= 1; m_err <= 1;
                end
            end
        end
    end

    logic e_snd;
    logic [N-1:0] e_done, e_err, e_ss;
    always_comb begin
        e_snd = m_act && !m_fin && m_age == 1;
        e_done = m_fin ? N'(1) << m_own : '0;
        e_err = (m_fin && m_err) ? N'(1) << m_own : '0;
        e_ss = '1;
        if (m_act) e_ss[m_own] = mnrch_SS_n;
    end

    initial forever begin
        @(posedge clk);
        #3;
        chk("cycle", {snd, cmd, done, err, resp, SS_n}, {e_snd, m_cmd, e_done, e_err, m_resp, e_ss});
    end

    // SPI engine stand-in: drops done/SS on snd, optionally keeps a stale high, then completes or hangs
    initial begin
        spi_done = 1'b1; mnrch_SS_n = 1'b1; spi_resp = '0;
        forever begin
            @(negedge clk);
            if (snd && !rst) begin
                logic aborted;
                aborted = 1'b0;
                mnrch_SS_n = 1'b0;
                if (hold_hi == 0) spi_done = 1'b0;
                for (int i = 1; i <= hold_hi + delay; i++) begin
                    @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    if (i == hold_hi) spi_done = 1'b0;
                end
                if (aborted) begin
                    spi_done = 1'b1; mnrch_SS_n = 1'b1;
                end else if (hang) begin
                    for (int i = 0; i < TMO + 20 && !(|done); i++) @(negedge clk);
                    mnrch_SS_n = 1'b1;
                end else begin
                    spi_resp = slv_resp; spi_done = 1'b1; mnrch_SS_n = 1'b1; rise_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_snd(input string nm, output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (snd) begin c = cyc; return; end
        end
        timeout(nm);
    endtask

    task automatic wait_done(input string nm, input int max, output logic [N-1:0] d, output int c);
        d = '0; c = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (|done) begin d = done; c = cyc; return; end
        end
        timeout(nm);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n, sc, dc, cnt;
        logic [N-1:0] d;
        logic [7:0] ord;
        do_reset();
        @(negedge clk);
        chk("reset_outs", {snd, cmd, done, err, resp, SS_n}, {1'b0, 16'h0, 2'b00, 2'b00, 16'h0, 2'b11});

        // single request from requester 0
        req_cmd = {16'h0000, 16'hA400}; slv_resp = 16'h0012; delay = 6;
        req = 2'b01; n = cyc;
        wait_snd("t1_snd", sc);
        chk("t1_snd_lat", sc - n, 2);
        chk("t1_cmd", cmd, 16'hA400);
        @(negedge clk); #1;
        chk("t1_ss", SS_n, 2'b10);
        wait_done("t1_done", 100, d, dc);
        chk("t1_done", d, 2'b01);
        chk("t1_err", err, 2'b00);
        chk("t1_resp", resp, 16'h0012);
        req = 2'b00;

        // both requesting after reset: strict alternation starting at 0
        do_reset();
        req_cmd = {16'h2222, 16'h1111}; slv_resp = 16'h0101; req = 2'b11;
        ord = '0;
        for (int k = 0; k < 4; k++) begin
            wait_done("t2_done", 100, d, dc);
            ord = {ord[5:0], d};
        end
        req = 2'b00;
        chk("t2_order", ord, 8'b01_10_01_10);

        // stale high spi_done must not complete; late rising edge does
        hold_hi = 5; delay = 40; slv_resp = 16'h3C3C; req = 2'b10;
        wait_done("t3_done", 150, d, dc);
        req = 2'b00;
        chk("t3_done", d, 2'b10);
        chk("t3_lat", dc - rise_cyc, 1);
        chk("t3_resp", resp, 16'h3C3C);
        hold_hi = 0;

        // engine never finishes: watchdog aborts
        hang = 1'b1; delay = 0; req = 2'b01;
        wait_snd("t4_snd", sc);
        wait_done("t4_done", TMO + 40, d, dc);
        chk("t4_lat", dc - sc, 64);
        chk("t4_done", d, 2'b01);
        chk("t4_err", err, 2'b01);
        chk("t4_resp", resp, 16'hFFFF);
        req = 2'b00; hang = 1'b0;
        @(negedge clk);
        delay = 8; slv_resp = 16'h0BEE; req = 2'b10;
        wait_done("t4b_done", 100, d, dc);
        chk("t4b_done", d, 2'b10);
        chk("t4b_err", err, 2'b00);
        chk("t4b_resp", resp, 16'h0BEE);
        req = 2'b00;

        // reset in the middle of a transfer
        delay = 30; slv_resp = 16'h5555; req = 2'b01;
        wait_snd("t5_snd", sc);
        repeat (5) @(negedge clk);
        rst = 1'b1; req = 2'b00;
        #1;
        chk("t5_rst_outs", {snd, cmd, done, err, resp, SS_n}, {1'b0, 16'h0, 2'b00, 2'b00, 16'h0, 2'b11});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (|done) cnt++;
        end
        chk("t5_no_done", cnt, 0);
        delay = 5; slv_resp = 16'h7777; req = 2'b11;
        wait_done("t5_fresh", 100, d, dc);
        req = 2'b00;
        chk("t5_fresh_owner", d, 2'b01);
        chk("t5_fresh_resp", resp, 16'h7777);

        // requester drops req right after snd
        delay = 10; slv_resp = 16'h00C3; req_cmd = {16'h2222, 16'hBEEF}; req = 2'b01;
        wait_snd("t6_snd", sc);
        chk("t6_cmd", cmd, 16'hBEEF);
        @(negedge clk);
        req = 2'b00;
        wait_done("t6_done", 100, d, dc);
        chk("t6_done", d, 2'b01);
        chk("t6_resp", resp, 16'h00C3);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
